// File: rtl/movwide_encoder_pkg.sv
// Shared opcodes, field positions and state encoding for the
// LEGv8 MOVZ/MOVK wide-immediate instruction path.
package movwide_encoder_pkg;

    localparam logic [8:0] MOVZ_OPC = 9'b110100101;
    localparam logic [8:0] MOVK_OPC = 9'b111100101;

    localparam int OPC_MSB   = 31;
    localparam int HW_LSB    = 21;
    localparam int IMM16_LSB = 5;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    function automatic logic [31:0] mw_instr(
        input logic [8:0]  opc,
        input logic [1:0]  hw,
        input logic [15:0] imm,
        input logic [4:0]  rd
    );
        logic [31:0] w;
        w = '0;
        w[OPC_MSB -: 9]     = opc;
        w[HW_LSB +: 2]      = hw;
        w[IMM16_LSB +: 16]  = imm;
        w[4:0]              = rd;
        return w;
    endfunction

endpackage

// File: rtl/movwide_encoder_pick.sv
// Lowest-set-bit picker over the pending halfword mask: one-hot,
// binary halfword index and a single-bit-remaining flag.
module movwide_pick (
    input  logic [3:0] i_pend,
    output logic [3:0] o_onehot,
    output logic [1:0] o_hw,
    output logic       o_single
);

    always_comb begin
        o_onehot = 4'b0000;
        o_hw     = 2'd0;
        // Several bits may be set; lowest index wins.
        priority case (1'b1)
            i_pend[0]: begin
                o_onehot = 4'b0001;
                o_hw     = 2'd0;
            end
            i_pend[1]: begin
                o_onehot = 4'b0010;
                o_hw     = 2'd1;
            end
            i_pend[2]: begin
                o_onehot = 4'b0100;
                o_hw     = 2'd2;
            end
            i_pend[3]: begin
                o_onehot = 4'b1000;
                o_hw     = 2'd3;
            end
            default: begin
                o_onehot = 4'b0000;
                o_hw     = 2'd0;
            end
        endcase
    end

    assign o_single = (i_pend != 4'd0)
                   && ((i_pend & (i_pend - 4'd1)) == 4'd0);

endmodule

// File: rtl/movwide_encoder.sv
// Streams a 64-bit constant out as a MOVZ/MOVK sequence, one word
// per accepted handshake, lowest halfword first.
module movwide_encoder
    import movwide_encoder_pkg::*;
#(
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        InValid,
    output logic        InReady,
    input  logic [63:0] Value,
    input  logic [4:0]  Rd,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] Instr,
    output logic        Last,
    output logic        Busy
);

    logic [0:0]  r_state;
    logic [63:0] r_value;
    logic [4:0]  r_rd;
    logic [3:0]  r_pend;
    logic [3:0]  r_hot;
    logic [31:0] r_instr;
    logic        r_valid;
    logic        r_last;

    logic [3:0]  w_pend_raw;
    logic [3:0]  w_pend_new;
    logic [3:0]  w_pend_next;
    logic [3:0]  w_sel_pend;
    logic [3:0]  w_sel_hot;
    logic [1:0]  w_sel_hw;
    logic        w_sel_single;
    logic [63:0] w_sel_value;
    logic [4:0]  w_sel_rd;
    logic [15:0] w_sel_imm;
    logic [8:0]  w_sel_opc;
    logic [31:0] w_sel_instr;
    logic        w_idle;

    assign w_idle = (r_state == IDLE);

    always_comb begin
        w_pend_raw = 4'b0000;
        for (int h = 0; h < 4; h++) begin
            w_pend_raw[h] = SKIP_ZERO ? (Value[16*h +: 16] != 16'h0) : 1'b1;
        end
    end

    // A zero constant still needs one MOVZ to clear the register.
    assign w_pend_new  = (w_pend_raw == 4'd0) ? 4'b0001 : w_pend_raw;
    assign w_pend_next = r_pend & ~r_hot;

    assign w_sel_pend  = w_idle ? w_pend_new : w_pend_next;
    assign w_sel_value = w_idle ? Value : r_value;
    assign w_sel_rd    = w_idle ? Rd : r_rd;
    assign w_sel_opc   = w_idle ? MOVZ_OPC : MOVK_OPC;

    movwide_pick u_pick (
        .i_pend   (w_sel_pend),
        .o_onehot (w_sel_hot),
        .o_hw     (w_sel_hw),
        .o_single (w_sel_single)
    );

    assign w_sel_imm   = w_sel_value[{w_sel_hw, 4'b0000} +: 16];
    assign w_sel_instr = mw_instr(w_sel_opc, w_sel_hw, w_sel_imm, w_sel_rd);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= IDLE;
            r_value <= '0;
            r_rd    <= '0;
            r_pend  <= '0;
            r_hot   <= '0;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_idle) begin
            if (InValid) begin
                r_state <= EMIT;
                r_value <= Value;
                r_rd    <= Rd;
                r_pend  <= w_pend_new;
                r_hot   <= w_sel_hot;
                r_instr <= w_sel_instr;
                r_valid <= 1'b1;
                r_last  <= w_sel_single;
            end
        end else if (r_valid && OutReady) begin
            if (r_last) begin
                r_state <= IDLE;
                r_pend  <= '0;
                r_hot   <= '0;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else begin
                r_pend  <= w_pend_next;
                r_hot   <= w_sel_hot;
                r_instr <= w_sel_instr;
                r_last  <= w_sel_single;
            end
        end
    end

    assign InReady  = w_idle;
    assign Busy     = (r_state == EMIT);
    assign OutValid = r_valid;
    assign Instr    = r_instr;
    assign Last     = r_last;

endmodule

// File: tb/tb_movwide_encoder.sv
// Bench for movwide_encoder: two instances (halfword skipping on/off)
// checked every cycle against a queue-based model of the word stream.
`timescale 1ns/1ps
module tb_movwide_encoder;

    typedef logic [32:0] wq_t[$];

    localparam logic [8:0] OPZ = 9'h1A5;
    localparam logic [8:0] OPK = 9'h1E5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv_a, ordy_a, irdy_a, ov_a, last_a, busy_a;
    logic [63:0] val_a;
    logic [4:0]  rd_a;
    logic [31:0] instr_a;
    logic        iv_b, ordy_b, irdy_b, ov_b, last_b, busy_b;
    logic [63:0] val_b;
    logic [4:0]  rd_b;
    logic [31:0] instr_b;

    movwide_encoder #(.SKIP_ZERO(1'b1)) dut_a (
        .CLK(clk), .Reset(rst), .InValid(iv_a), .InReady(irdy_a),
        .Value(val_a), .Rd(rd_a), .OutValid(ov_a), .OutReady(ordy_a),
        .Instr(instr_a), .Last(last_a), .Busy(busy_a)
    );

    movwide_encoder #(.SKIP_ZERO(1'b0)) dut_b (
        .CLK(clk), .Reset(rst), .InValid(iv_b), .InReady(irdy_b),
        .Value(val_b), .Rd(rd_b), .OutValid(ov_b), .OutReady(ordy_b),
        .Instr(instr_b), .Last(last_b), .Busy(busy_b)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Word list from the encoding rules: {last, opc, hw, imm16, rd}.
    function automatic wq_t expect_words(input logic [63:0] v,
                                         input logic [4:0] r,
                                         input bit skip);
        wq_t q;
        int hs[$];
        logic [1:0]  hw;
        logic [8:0]  opc;
        logic [15:0] imm;
        logic        lst;
        for (int h = 0; h < 4; h++) begin
            if (!skip || ((v >> (16 * h)) & 64'hFFFF) != 64'h0)
                hs.push_back(h);
        end
        if (hs.size() == 0) hs.push_back(0);
        for (int i = 0; i < hs.size(); i++) begin
            hw  = 2'(hs[i]);
            opc = (i == 0) ? OPZ : OPK;
            imm = 16'((v >> (16 * hs[i])) & 64'hFFFF);
            lst = (i == hs.size() - 1);
            q.push_back({lst, opc, hw, imm, r});
        end
        return q;
    endfunction

    bit mon_en = 1'b0;
    wq_t qa, qb;
    logic [31:0] loga[$];
    logic [31:0] logb[$];
    bit after_rst_a = 1'b0;
    bit after_rst_b = 1'b0;

    always @(negedge clk) begin
        bit idle;
        if (mon_en) begin
            idle = (qa.size() == 0);
            if (after_rst_a) chk("a_rst_instr", 64'(instr_a), 64'h0);
            chk("a_outvalid", 64'(ov_a), 64'(!idle));
            chk("a_inready", 64'(irdy_a), 64'(idle));
            chk("a_busy", 64'(busy_a), 64'(!idle));
            if (!idle) begin
                chk("a_instr", 64'(instr_a), 64'(qa[0][31:0]));
                chk("a_last", 64'(last_a), 64'(qa[0][32]));
            end
            if (rst) begin
                qa.delete();
                after_rst_a = 1'b1;
            end else begin
                after_rst_a = 1'b0;
                if (ov_a && ordy_a) loga.push_back(instr_a);
                if (!idle && ordy_a) void'(qa.pop_front());
                if (idle && iv_a) qa = expect_words(val_a, rd_a, 1'b1);
            end
        end
    end

    always @(negedge clk) begin
        bit idle;
        if (mon_en) begin
            idle = (qb.size() == 0);
            if (after_rst_b) chk("b_rst_instr", 64'(instr_b), 64'h0);
            chk("b_outvalid", 64'(ov_b), 64'(!idle));
            chk("b_inready", 64'(irdy_b), 64'(idle));
            chk("b_busy", 64'(busy_b), 64'(!idle));
            if (!idle) begin
                chk("b_instr", 64'(instr_b), 64'(qb[0][31:0]));
                chk("b_last", 64'(last_b), 64'(qb[0][32]));
            end
            if (rst) begin
                qb.delete();
                after_rst_b = 1'b1;
            end else begin
                after_rst_b = 1'b0;
                if (ov_b && ordy_b) logb.push_back(instr_b);
                if (!idle && ordy_b) void'(qb.pop_front());
                if (idle && iv_b) qb = expect_words(val_b, rd_b, 1'b0);
            end
        end
    end

    // OutReady: 0 = always, 1 = 1,0,0 pattern, 2 = random, 3 = manual.
    int rmode = 0;
    int ph = 0;
    logic man_ordy = 1'b1;
    always @(posedge clk) begin
        #1;
        if (rmode == 1) begin
            ordy_a = (ph % 3 == 0);
            ordy_b = 1'b1;
            ph++;
        end else if (rmode == 2) begin
            ordy_a = 1'($urandom_range(0, 1));
            ordy_b = 1'($urandom_range(0, 1));
        end else if (rmode == 3) begin
            ordy_a = man_ordy;
            ordy_b = 1'b1;
        end else begin
            ordy_a = 1'b1;
            ordy_b = 1'b1;
        end
    end

    task automatic send(input bit b, input logic [63:0] v, input logic [4:0] r);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        if (b) begin
            val_b = v; rd_b = r; iv_b = 1'b1;
        end else begin
            val_a = v; rd_a = r; iv_a = 1'b1;
        end
        @(negedge clk);
        while (!(b ? irdy_b : irdy_a) && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (n >= 300) chk("send_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        iv_a = 1'b0;
        iv_b = 1'b0;
    endtask

    task automatic wait_idle(input bit b);
        int n;
        n = 0;
        @(negedge clk);
        while (!(b ? (irdy_b && !ov_b) : (irdy_a && !ov_a)) && n < 400) begin
            n++;
            @(negedge clk);
        end
        if (n >= 400) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        wq_t q;
        logic [63:0] v, ext;
        logic [15:0] imm;
        logic [1:0]  hw;
        logic [31:0] w;
        int n;

        rst = 1'b1;
        iv_a = 1'b0; val_a = '0; rd_a = '0;
        iv_b = 1'b0; val_b = '0; rd_b = '0;
        ordy_a = 1'b1; ordy_b = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        q = expect_words(64'h1111_0000_2222_0000, 5'd2, 1'b1);
        chk("model_t3_size", 64'(q.size()), 64'd2);
        chk("model_t3_w0", 64'(q[0]), {31'd0, 1'b0, 32'hD2A44442});
        chk("model_t3_w1", 64'(q[1]), {31'd0, 1'b1, 32'hF2E22222});
        q = expect_words(64'h0, 5'd5, 1'b0);
        chk("model_skip0_size", 64'(q.size()), 64'd4);

        // Zero constant -> single MOVZ, InReady back two cycles after accept
        loga.delete();
        send(1'b0, 64'h0, 5'd5);
        @(negedge clk);
        chk("t1_inready_c1", 64'(irdy_a), 64'd0);
        chk("t1_last_c1", 64'(last_a), 64'd1);
        @(negedge clk);
        chk("t1_inready_c2", 64'(irdy_a), 64'd1);
        wait_idle(1'b0);
        chk("t1_count", 64'(loga.size()), 64'd1);
        if (loga.size() > 0) chk("t1_word", 64'(loga[0]), 64'hD2800005);

        loga.delete();
        send(1'b0, 64'h0000_0000_0000_1234, 5'd1);
        wait_idle(1'b0);
        chk("t2_count", 64'(loga.size()), 64'd1);
        if (loga.size() > 0) chk("t2_word", 64'(loga[0]), 64'hD2824681);

        loga.delete();
        send(1'b0, 64'h1111_0000_2222_0000, 5'd2);
        wait_idle(1'b0);
        chk("t3_count", 64'(loga.size()), 64'd2);
        if (loga.size() > 1) begin
            chk("t3_w0", 64'(loga[0]), 64'hD2A44442);
            chk("t3_w1", 64'(loga[1]), 64'hF2E22222);
        end

        // All-ones under a stalling consumer; decode each word back
        rmode = 1;
        loga.delete();
        send(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3);
        wait_idle(1'b0);
        chk("t4_count", 64'(loga.size()), 64'd4);
        for (int i = 0; i < loga.size() && i < 4; i++) begin
            w   = loga[i];
            imm = w[20:5];
            hw  = w[22:21];
            ext = 64'(imm) << (16 * hw);
            chk("t4_signext", ext, 64'hFFFF << (16 * i));
            chk("t4_opc", 64'(w[31:23]), 64'((i == 0) ? OPZ : OPK));
        end

        // Reset while the second word is stalled
        rmode = 3;
        man_ordy = 1'b1;
        loga.delete();
        send(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3);
        @(negedge clk);
        man_ordy = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_outvalid", 64'(ov_a), 64'd0);
        chk("t5_inready", 64'(irdy_a), 64'd1);
        chk("t5_instr", 64'(instr_a), 64'd0);
        chk("t5_pre_count", 64'(loga.size()), 64'd1);
        man_ordy = 1'b1;
        loga.delete();
        send(1'b0, 64'h5, 5'd0);
        wait_idle(1'b0);
        chk("t5_count", 64'(loga.size()), 64'd1);
        if (loga.size() > 0) chk("t5_word", 64'(loga[0]), 64'hD28000A0);

        // No skipping: four words, InValid held high the whole time
        rmode = 0;
        logb.delete();
        @(posedge clk); #1;
        val_b = 64'h0000_0000_0000_00AB;
        rd_b = 5'd7;
        iv_b = 1'b1;
        n = 0;
        @(posedge clk);
        while (logb.size() < 4 && n < 100) begin
            n++;
            @(posedge clk);
        end
        if (n >= 100) chk("t6_timeout", 64'd1, 64'd0);
        #1;
        chk("t6_busy_at_4th", 64'(busy_b), 64'd0);
        @(posedge clk); #1;
        iv_b = 1'b0;
        wait_idle(1'b1);
        chk("t6_count", 64'(logb.size()), 64'd8);
        if (logb.size() >= 4) begin
            chk("t6_w0", 64'(logb[0]), 64'hD2801567);
            chk("t6_w1", 64'(logb[1]), 64'hF2A00007);
            chk("t6_w2", 64'(logb[2]), 64'hF2C00007);
            chk("t6_w3", 64'(logb[3]), 64'hF2E00007);
        end

        // Random constants with sparse halfwords and random back-pressure
        rmode = 2;
        for (int k = 0; k < 80; k++) begin
            v = '0;
            for (int h = 0; h < 4; h++) begin
                if ($urandom_range(0, 1) == 1)
                    v = v | (64'($urandom_range(0, 65535)) << (16 * h));
            end
            send(1'($urandom_range(0, 1)), v, 5'($urandom_range(0, 31)));
        end
        wait_idle(1'b0);
        wait_idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
